// File: rtl/fc2_weight_loader.sv
// fc2_weight_loader: streams FC2 weights and biases into the weight/bias
// memories and gates the FC2 start pulse until a full weight set is resident.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   load_start, load_abort begin / cancel a weight+bias load (pulses)
//   in_data, in_valid      load stream word and its valid
//   in_ready               word accepted this cycle (LOAD_WM / LOAD_BM)
//   riscv_data             registered memory write data
//   riscv_address          registered memory write address (zero-extended)
//   wm_enable_write        one-hot weight-memory write strobe
//   bm_enable_write        bias-memory write strobe
//   load_busy              load in progress
//   weights_valid          complete weight set resident
//   start_from_previous    inference start from the upstream layer
//   start_fc2              gated start to FC2 (1 cycle later)
//   start_dropped          start rejected, weights not valid (1 cycle later)

module fc2_weight_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 15,
  parameter int IFM_DEPTH    = 84,
  parameter int NUMBER_OF_WM = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_abort,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   riscv_data,
  output logic [ADDRESS_BITS-1:0] riscv_address,
  output logic [NUMBER_OF_WM-1:0] wm_enable_write,
  output logic                    bm_enable_write,
  output logic                    load_busy,
  output logic                    weights_valid,
  input  logic                    start_from_previous,
  output logic                    start_fc2,
  output logic                    start_dropped
);

  // word_idx counts weight words and also bias words, so it must
  // cover the larger of the two ranges.
  localparam int WI_MAX =
    (IFM_DEPTH > NUMBER_OF_WM) ? IFM_DEPTH : NUMBER_OF_WM;
  localparam int WI_W =
    (WI_MAX > 1) ? $clog2(WI_MAX) : 1;
  localparam int WM_W =
    (NUMBER_OF_WM > 1) ? $clog2(NUMBER_OF_WM) : 1;

  localparam logic [WI_W-1:0] LAST_WORD =
    WI_W'(IFM_DEPTH - 1);
  localparam logic [WI_W-1:0] LAST_BIAS =
    WI_W'(NUMBER_OF_WM - 1);
  localparam logic [WM_W-1:0] LAST_WM =
    WM_W'(NUMBER_OF_WM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WM,
    LOAD_BM,
    READY
  } state_t;

  state_t                  state;
  logic [WI_W-1:0]         word_idx;
  logic [WM_W-1:0]         wm_idx;
  logic                    loading;
  logic                    accept;
  logic                    can_start;
  logic [NUMBER_OF_WM-1:0] wm_onehot;

  assign loading   = (state == LOAD_WM) ||
                     (state == LOAD_BM);
  assign in_ready  = loading;
  assign load_busy = loading;
  assign accept    = in_valid & loading;
  assign can_start = (state == READY) & weights_valid;
  assign wm_onehot = NUMBER_OF_WM'(1) << wm_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      word_idx        <= '0;
      wm_idx          <= '0;
      riscv_data      <= '0;
      riscv_address   <= '0;
      wm_enable_write <= '0;
      bm_enable_write <= 1'b0;
      weights_valid   <= 1'b0;
      start_fc2       <= 1'b0;
      start_dropped   <= 1'b0;
    end else begin
      // Strobes are single-cycle; any accept below re-raises one.
      wm_enable_write <= '0;
      bm_enable_write <= 1'b0;

      // Gating looks at the state before this edge, so a start
      // coincident with load_start in READY is still honoured.
      start_fc2     <= start_from_previous & can_start;
      start_dropped <= start_from_previous & ~can_start;

      if (load_abort) begin
        // Abort wins over load_start and swallows any accept.
        state         <= IDLE;
        weights_valid <= 1'b0;
        word_idx      <= '0;
        wm_idx        <= '0;
      end else begin
        case (state)
          IDLE, READY: begin
            if (load_start) begin
              state         <= LOAD_WM;
              word_idx      <= '0;
              wm_idx        <= '0;
              weights_valid <= 1'b0;
            end
          end

          LOAD_WM: begin
            if (accept) begin
              riscv_data      <= in_data;
              riscv_address   <=
                ADDRESS_BITS'(word_idx);
              wm_enable_write <= wm_onehot;
              if (word_idx == LAST_WORD) begin
                word_idx <= '0;
                if (wm_idx == LAST_WM) begin
                  wm_idx <= '0;
                  state  <= LOAD_BM;
                end else begin
                  wm_idx <= wm_idx + 1'b1;
                end
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end

          LOAD_BM: begin
            if (accept) begin
              riscv_data      <= in_data;
              riscv_address   <=
                ADDRESS_BITS'(word_idx);
              bm_enable_write <= 1'b1;
              if (word_idx == LAST_BIAS) begin
                word_idx      <= '0;
                state         <= READY;
                weights_valid <= 1'b1;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Write strobes are mutually exclusive and at most one-hot.
  a_strobe_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(bm_enable_write && (|wm_enable_write))
  );

  a_wm_onehot: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(wm_enable_write)
  );

endmodule

// File: tb/tb_fc2_weight_loader.sv
// tb_fc2_weight_loader: scoreboard bench for fc2_weight_loader.
// Directed loads, aborts, resets and start gating.

module tb_fc2_weight_loader;

  localparam int DW    = 32;
  localparam int AB    = 15;
  localparam int DEPTH = 84;
  localparam int NWM   = 10;
  localparam int NWGT  = DEPTH * NWM;
  localparam int NW    = NWGT + NWM;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load_start = 1'b0;
  logic           load_abort = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  riscv_data;
  logic [AB-1:0]  riscv_address;
  logic [NWM-1:0] wm_enable_write;
  logic           bm_enable_write;
  logic           load_busy;
  logic           weights_valid;
  logic           start_from_previous = 1'b0;
  logic           start_fc2;
  logic           start_dropped;

  fc2_weight_loader #(
    .DATA_WIDTH   (DW),
    .ADDRESS_BITS (AB),
    .IFM_DEPTH    (DEPTH),
    .NUMBER_OF_WM (NWM)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .load_start          (load_start),
    .load_abort          (load_abort),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .riscv_data          (riscv_data),
    .riscv_address       (riscv_address),
    .wm_enable_write     (wm_enable_write),
    .bm_enable_write     (bm_enable_write),
    .load_busy           (load_busy),
    .weights_valid       (weights_valid),
    .start_from_previous (start_from_previous),
    .start_fc2           (start_fc2),
    .start_dropped       (start_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic           bm;
    logic [NWM-1:0] wm;
    logic [AB-1:0]  addr;
    logic [DW-1:0]  data;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } st_t;

  localparam logic [1:0] ST_FC2  = 2'b10;
  localparam logic [1:0] ST_DROP = 2'b01;

  wr_t wq[$];
  st_t sq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  widx  = 0;

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Expected write for the widx-th accepted word of a load.
  function automatic void push_word(input logic [DW-1:0] d);
    wr_t e;
    e.cyc = cyc + 1;
    if (widx < NWGT) begin
      e.bm   = 1'b0;
      e.wm   = NWM'(1) << (widx / DEPTH);
      e.addr = AB'(widx % DEPTH);
    end else begin
      e.bm   = 1'b1;
      e.wm   = '0;
      e.addr = AB'(widx - NWGT);
    end
    e.data = d;
    wq.push_back(e);
    widx++;
  endfunction

  // Monitor: every strobe / start pulse is matched against the queues.
  initial begin
    wr_t e;
    st_t s;
    forever begin
      @(negedge clk);
      if ((|wm_enable_write) || bm_enable_write) begin
        if (wq.size() == 0) begin
          check("unexpected_write",
                64'({bm_enable_write, wm_enable_write}), 64'(0));
        end else begin
          e = wq.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.cyc));
          check("write",
                64'({bm_enable_write, wm_enable_write,
                     riscv_address, riscv_data}),
                64'({e.bm, e.wm, e.addr, e.data}));
        end
      end
      if (start_fc2 || start_dropped) begin
        if (sq.size() == 0) begin
          check("unexpected_start",
                64'({start_fc2, start_dropped}), 64'(0));
        end else begin
          s = sq.pop_front();
          check("start_cycle", 64'(cyc), 64'(s.cyc));
          check("start_code",
                64'({start_fc2, start_dropped}), 64'(s.code));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic ls);
    int w = 0;
    in_data    = d;
    in_valid   = 1'b1;
    load_start = ls;
    while (!in_ready && w < 8) begin
      tick();
      load_start = 1'b0;
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'(1));
    end else begin
      push_word(d);
    end
    tick();
    in_valid   = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] code);
    st_t s;
    start_from_previous = 1'b1;
    s.cyc  = cyc + 1;
    s.code = code;
    sq.push_back(s);
    tick();
    start_from_previous = 1'b0;
  endtask

  task automatic begin_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    widx = 0;
  endtask

  // Sends words [0, n); optional random idle gaps and a stray
  // load_start on word index restart_at.
  task automatic stream(input int n, input bit rnd,
                        input int restart_at, input logic [7:0] tag);
    for (int i = 0; i < n; i++) begin
      if (rnd) repeat ($urandom_range(0, 1)) tick();
      send({tag, 24'(i * 3 + 7)}, i == restart_at);
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    check(nm,
          64'({in_ready, load_busy, weights_valid, start_fc2,
               start_dropped, bm_enable_write, wm_enable_write,
               riscv_address}),
          64'(0));
    check({nm, "_data"}, 64'(riscv_data), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset_values");
    reset = 1'b0;
    tick();
    check_zero_outputs("idle_after_reset");

    // Start before any load is rejected.
    pulse_start(ST_DROP);

    // Abort and start together: abort wins, nothing starts.
    load_start = 1'b1;
    load_abort = 1'b1;
    tick();
    load_start = 1'b0;
    load_abort = 1'b0;
    check("abort_beats_start", 64'({in_ready, load_busy}), 64'(0));

    // Full continuous load; stray load_start on word 101.
    begin_load();
    check("busy_in_load", 64'({in_ready, load_busy}), 64'(3));
    check("wv_cleared", 64'(weights_valid), 64'(0));
    stream(NW, 1'b0, 100, 8'hA1);
    check("load1_done",
          64'({weights_valid, in_ready, load_busy}), 64'(4));
    pulse_start(ST_FC2);

    // Same load with random valid gaps.
    begin_load();
    stream(NW, 1'b1, -1, 8'hB2);
    check("load2_done",
          64'({weights_valid, in_ready, load_busy}), 64'(4));
    pulse_start(ST_FC2);

    // Start coincident with load_start in READY.
    begin
      st_t s;
      s.cyc  = cyc + 1;
      s.code = ST_FC2;
      sq.push_back(s);
    end
    start_from_previous = 1'b1;
    load_start = 1'b1;
    tick();
    start_from_previous = 1'b0;
    load_start = 1'b0;
    widx = 0;
    check("coincident_load",
          64'({weights_valid, in_ready}), 64'(1));

    // Abort after word 400, with a word offered on the abort edge.
    stream(400, 1'b0, -1, 8'hC3);
    load_abort = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hDEAD_BEEF;
    tick();
    load_abort = 1'b0;
    in_valid   = 1'b0;
    check("after_abort",
          64'({in_ready, load_busy, weights_valid}), 64'(0));
    pulse_start(ST_DROP);

    // Full load after abort starts again from address 0.
    begin_load();
    stream(NW, 1'b0, -1, 8'hD4);
    check("load3_done",
          64'({weights_valid, in_ready}), 64'(2));

    // Reset at word 845 discards the partial load.
    begin_load();
    stream(845, 1'b0, -1, 8'hE5);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    tick();
    check_zero_outputs("reset_mid_load");
    reset    = 1'b0;
    in_valid = 1'b0;
    pulse_start(ST_DROP);

    repeat (4) tick();
    check("writes_drained", 64'(wq.size()), 64'(0));
    check("starts_drained", 64'(sq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc2_weight_loader.md
FC2_WEIGHT_LOADER -- requirements
Module: fc2_weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of load and memory write data.
REQ-002 Parameter ADDRESS_BITS, default 15, width of riscv_address.
REQ-003 Parameter IFM_DEPTH, default 84, weight words per weight memory.
REQ-004 Parameter NUMBER_OF_WM, default 10, number of weight memories; also the number of bias words.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_start  input  1  single-cycle pulse; begins a full weight+bias load.
REQ-008 load_abort  input  1  single-cycle pulse; cancels a load in progress.
REQ-009 in_data  input  DATA_WIDTH  load stream word.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 riscv_data  output  DATA_WIDTH  memory write data, registered.
REQ-013 riscv_address  output  ADDRESS_BITS  memory write address, registered, zero-extended.
REQ-014 wm_enable_write  output  NUMBER_OF_WM  one-hot weight-memory write strobe.
REQ-015 bm_enable_write  output  1  bias-memory write strobe.
REQ-016 load_busy  output  1  high in LOAD_WM or LOAD_BM.
REQ-017 weights_valid  output  1  complete weight set resident.
REQ-018 start_from_previous  input  1  inference start pulse from the upstream layer.
REQ-019 start_fc2  output  1  gated start pulse to the FC2 layer.
REQ-020 start_dropped  output  1  pulse: start rejected because weights not valid.

Function
REQ-021 States IDLE, LOAD_WM, LOAD_BM, READY; counters word_idx (0..IFM_DEPTH-1) and wm_idx (0..NUMBER_OF_WM-1).
REQ-022 IDLE/READY + load_start -> LOAD_WM; word_idx=0, wm_idx=0, weights_valid cleared the same edge.
REQ-023 load_start in LOAD_WM/LOAD_BM ignored; counters unaffected.
REQ-024 in_ready = 1 exactly in LOAD_WM and LOAD_BM (combinational from state); 0 otherwise.
REQ-025 Accept = in_valid & in_ready; non-accept cycles: no strobe, counters hold.
REQ-026 LOAD_WM accept: next edge riscv_data=in_data, riscv_address=word_idx, wm_enable_write=one-hot bit wm_idx for exactly one cycle (latency 1).
REQ-027 LOAD_WM: word_idx increments per accept; at IFM_DEPTH-1 wraps to 0 and wm_idx increments.
REQ-028 Accept with word_idx=IFM_DEPTH-1 and wm_idx=NUMBER_OF_WM-1 -> LOAD_BM, word_idx=0.
REQ-029 LOAD_BM accept: next edge riscv_data=in_data, riscv_address=word_idx, bm_enable_write=1 for one cycle; word_idx increments.
REQ-030 Accept with word_idx=NUMBER_OF_WM-1 in LOAD_BM -> READY, weights_valid=1 same edge as final strobe.
REQ-031 Total accepted words per load = IFM_DEPTH*NUMBER_OF_WM + NUMBER_OF_WM (850 default).
REQ-032 wm_enable_write and bm_enable_write never high simultaneously; at most one wm_enable_write bit high.
REQ-033 load_abort in any state -> IDLE, weights_valid=0, counters 0; a write registered on the abort edge is suppressed (no strobe next cycle).
REQ-034 load_abort and load_start same cycle: abort wins.
REQ-035 start_fc2 = registered pulse, 1 cycle after start_from_previous when weights_valid=1 and state READY.
REQ-036 start_from_previous when not READY/weights_valid=0: no start_fc2; start_dropped pulses 1 cycle later.
REQ-037 start_from_previous coincident with load_start in READY: start_fc2 issued, load begins; weights_valid cleared after that edge.
REQ-038 riscv_data/riscv_address hold last written value when no strobe.

Reset
REQ-039 reset (sync, active-high) -> IDLE, word_idx=0, wm_idx=0.
REQ-040 Reset values: in_ready=0, riscv_data=0, riscv_address=0, wm_enable_write=0, bm_enable_write=0, load_busy=0, weights_valid=0, start_fc2=0, start_dropped=0.
REQ-041 Reset mid-load discards partial load; reset has priority over all inputs.

Verification
REQ-042 load_start, then 850 words with in_valid=1 continuously -> wm_enable_write bit k pulses 84 times at addresses 0..83 for k=0..9, then 10 bm_enable_write pulses at addresses 0..9, weights_valid=1 after word 850.
REQ-043 Same load with in_valid toggled randomly (50%) -> identical write sequence, no strobe on idle cycles.
REQ-044 start_from_previous before any load -> start_dropped=1 one cycle later, start_fc2=0; after full load -> start_fc2=1 one cycle later.
REQ-045 load_abort after word 400 -> no strobe next cycle, state IDLE, weights_valid=0, in_ready=0; subsequent full load completes correctly.
REQ-046 reset asserted at word 845 -> all outputs to REQ-040 values; start_from_previous afterwards -> start_dropped.
REQ-047 load_start pulsed again at word 100 -> ignored; write at word 101 goes to wm_enable_write[1], address 16.
